// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the PC fetch controller.
//   - NextInstrSel encodings produced by the PC decoder.
//   - Fetch FSM state type.
//   - Width of the flush down-counter. Its maximum count is 7.
//   - Helper that classifies a selector value as a taken-redirect kind.
package pc_ctrl_pkg;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Only branch and jump redirect. The reserved code falls back to sequential.
  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == SEL_BR) || (sel == SEL_JMP);
  endfunction

endpackage

// File: rtl/pc_flush_counter.sv
// pc_flush_counter: loadable down-counter with a zero flag. It sets how long
// the squash window lasts after a redirect.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   i_load      - load i_load_val. Load takes priority over decrement.
//   i_load_val  - value to load
//   i_dec       - decrement by one. The count stops at zero.
//   o_cnt       - current count (registered)
//   o_zero      - count equals zero
module pc_flush_counter
  import pc_ctrl_pkg::*;
#(
  parameter int W = FLUSH_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples pre-edge values, regardless of the order of the statements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the program counter. It consumes NextInstrSel from the
// PC decoder and runs an IDLE/RUN/FLUSH sequence. After a taken branch or
// jump, that sequence squashes the wrong-path instructions in the front end.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   NextInstrSel - 00 seq, 01 branch, 10 jump, 11 reserved (treated as seq)
//   sel_valid    - selector and targets are meaningful this cycle
//   branch_tgt   - branch target address
//   jmp_tgt      - jump target address
//   stall        - hold the PC
//   pc           - fetch address (registered)
//   fetch_valid  - instruction at pc is architecturally valid (registered)
//   flush        - squash front-end pipeline registers (registered)
//   redirect_cnt - saturating count of taken redirects. This port exists
//                  only when PC_REDIRECT_STATS_EN is defined.
// Optional feature macro: PC_REDIRECT_STATS_EN
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              PC_INC    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        NextInstrSel,
  input  logic              sel_valid,
  input  logic [ADDR_W-1:0] branch_tgt,
  input  logic [ADDR_W-1:0] jmp_tgt,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
`ifdef PC_REDIRECT_STATS_EN
  output logic              flush,
  output logic [15:0]       redirect_cnt
`else
  output logic              flush
`endif
);

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_pc;
  logic                     r_fetch_valid;
  logic                     r_flush;

  logic                     w_take;
  logic [ADDR_W-1:0]        w_tgt;
  logic [ADDR_W-1:0]        w_pc_inc;
  logic [FLUSH_CNT_W-1:0]   w_cnt;
  logic                     w_cnt_zero;
  logic                     w_flush_last;

  // Only RUN takes redirects. A stall blocks them, and the decoder holds
  // sel_valid until the stall drops.
  assign w_take   = (r_state == RUN) && sel_valid && !stall && is_redirect(NextInstrSel);
  assign w_tgt    = (NextInstrSel == SEL_JMP) ? jmp_tgt : branch_tgt;
  // Truncation to ADDR_W gives the modulo 2^ADDR_W wrap-around.
  assign w_pc_inc = r_pc + ADDR_W'(PC_INC);

  pc_flush_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_take),
    .i_load_val (FLUSH_CNT_W'(FLUSH_CYC)),
    .i_dec      (r_state == FLUSH),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Leave FLUSH on the cycle the counter shows 1. The zero term is a guard
  // that keeps the FSM from locking up in FLUSH.
  assign w_flush_last = (w_cnt == FLUSH_CNT_W'(1)) || w_cnt_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state       <= RUN;
          r_pc          <= RESET_PC;
          r_fetch_valid <= 1'b1;
          r_flush       <= 1'b0;
        end
        RUN: begin
          if (w_take) begin
            r_state       <= FLUSH;
            r_pc          <= w_tgt;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b1;
          end else if (!stall) begin
            r_pc <= w_pc_inc;
          end
        end
        FLUSH: begin
          // The PC walks forward from the target, so the target instruction
          // is fetched during the squash window. The window length ignores
          // stall.
          if (!stall) begin
            r_pc <= w_pc_inc;
          end
          if (w_flush_last) begin
            r_state       <= RUN;
            r_fetch_valid <= 1'b1;
            r_flush       <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_fetch_valid <= 1'b0;
          r_flush       <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign fetch_valid = r_fetch_valid;
  assign flush       = r_flush;

`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] r_redirect_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_redirect_cnt <= '0;
    end else if (w_take && (r_redirect_cnt != 16'hFFFF)) begin
      r_redirect_cnt <= r_redirect_cnt + 16'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed test of pc_fetch_ctrl with default parameters
// (ADDR_W=32, PC_INC=4, RESET_PC=0, FLUSH_CYC=2).
// Each step drives the inputs, pushes the expected post-edge outputs onto a
// scoreboard queue, and advances one clock. It then pops the entry and
// compares it against the DUT, 1 ns after the rising edge.
// Optional feature macro: PC_REDIRECT_STATS_EN
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  NextInstrSel;
  logic        sel_valid;
  logic [31:0] branch_tgt;
  logic [31:0] jmp_tgt;
  logic        stall;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] redirect_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .NextInstrSel (NextInstrSel),
    .sel_valid    (sel_valid),
    .branch_tgt   (branch_tgt),
    .jmp_tgt      (jmp_tgt),
    .stall        (stall),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
`ifdef PC_REDIRECT_STATS_EN
    .flush        (flush),
    .redirect_cnt (redirect_cnt)
`else
    .flush        (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock step. The expectation is queued when the stimulus is applied
  // and retired once the DUT output is sampled after the edge.
  task automatic cyc(input string tag, input logic [31:0] e_pc, input logic e_fv, input logic e_fl);
    exp_t e;
    sb.push_back('{tag: tag, pc: e_pc, fv: e_fv, fl: e_fl});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"},    pc,                  e.pc);
    check({e.tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, e.fv});
    check({e.tag, ".flush"}, {31'd0, flush},       {31'd0, e.fl});
  endtask

  task automatic check_cnt(input string tag, input int exp_cnt);
`ifdef PC_REDIRECT_STATS_EN
    check(tag, {16'd0, redirect_cnt}, exp_cnt);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; sel_valid = 1'b0; NextInstrSel = 2'b00;
    branch_tgt = 32'h0; jmp_tgt = 32'h0;

    // Reset, then sequential run from RESET_PC.
    cyc("rst0", 32'h0, 1'b0, 1'b0);
    cyc("rst1", 32'h0, 1'b0, 1'b0);
    check_cnt("cnt_rst", 0);
    rst_n = 1'b1;
    cyc("run0", 32'h0, 1'b1, 1'b0);
    cyc("seq4", 32'h4, 1'b1, 1'b0);
    cyc("seq8", 32'h8, 1'b1, 1'b0);

    // Branch at pc=8 to 0x100. A second branch to 0x200 inside FLUSH is ignored.
    sel_valid = 1'b1; NextInstrSel = 2'b01; branch_tgt = 32'h100;
    cyc("br_take", 32'h100, 1'b0, 1'b1);
    branch_tgt = 32'h200;
    cyc("br_fl1", 32'h104, 1'b0, 1'b1);
    cyc("br_fl2", 32'h108, 1'b1, 1'b0);
    sel_valid = 1'b0; NextInstrSel = 2'b00;
    check_cnt("cnt_br", 1);

    // Jump held off by a 3-cycle stall. A stall inside FLUSH holds the PC
    // but does not stretch the window.
    sel_valid = 1'b1; NextInstrSel = 2'b10; jmp_tgt = 32'h40; stall = 1'b1;
    cyc("jst1", 32'h108, 1'b1, 1'b0);
    cyc("jst2", 32'h108, 1'b1, 1'b0);
    cyc("jst3", 32'h108, 1'b1, 1'b0);
    stall = 1'b0;
    cyc("j_take", 32'h40, 1'b0, 1'b1);
    sel_valid = 1'b0; NextInstrSel = 2'b00; stall = 1'b1;
    cyc("j_fl_stall", 32'h40, 1'b0, 1'b1);
    stall = 1'b0;
    cyc("j_fl_end", 32'h44, 1'b1, 1'b0);
    check_cnt("cnt_j", 2);

    // The reserved selector acts as sequential.
    sel_valid = 1'b1; NextInstrSel = 2'b11;
    cyc("rsv1", 32'h48, 1'b1, 1'b0);
    cyc("rsv2", 32'h4C, 1'b1, 1'b0);

    // Reset in the middle of FLUSH.
    NextInstrSel = 2'b01; branch_tgt = 32'h300;
    cyc("br2_take", 32'h300, 1'b0, 1'b1);
    check_cnt("cnt_3", 3);
    sel_valid = 1'b0; NextInstrSel = 2'b00; rst_n = 1'b0;
    cyc("rst_mid", 32'h0, 1'b0, 1'b0);
    check_cnt("cnt_rst2", 0);
    rst_n = 1'b1;
    cyc("run0b", 32'h0, 1'b1, 1'b0);
    cyc("seq4b", 32'h4, 1'b1, 1'b0);

    // Jump near the top of the address space, then wrap from 0xFFFFFFFC.
    sel_valid = 1'b1; NextInstrSel = 2'b10; jmp_tgt = 32'hFFFF_FFF4;
    cyc("jw_take", 32'hFFFF_FFF4, 1'b0, 1'b1);
    sel_valid = 1'b0; NextInstrSel = 2'b00;
    cyc("jw_fl1", 32'hFFFF_FFF8, 1'b0, 1'b1);
    cyc("jw_fl2", 32'hFFFF_FFFC, 1'b1, 1'b0);
    cyc("wrap", 32'h0, 1'b1, 1'b0);
    cyc("wrap4", 32'h4, 1'b1, 1'b0);
    check_cnt("cnt_end", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Receiving end of the next-instruction select produced by the PC decoder.
- Consumes the 2-bit NextInstrSel encoding plus branch/jump targets; owns the program-counter register.
- After any taken redirect, drives a fetch-valid/flush sequence that squashes the wrong-path instructions already in the front end.
- Sits between the control/decode stage and instruction memory.

Parameters:
ADDR_W, 32, PC width in bits
PC_INC, 4, sequential PC increment (bytes per instruction)
RESET_PC, 0, PC value loaded on reset
FLUSH_CYC, 2, number of squash cycles after a taken redirect (1..7)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
NextInstrSel  in  2  from PC decoder: 00 seq, 01 branch, 10 jump, 11 reserved
sel_valid  in  1  NextInstrSel/targets are meaningful this cycle
branch_tgt  in  ADDR_W  branch target address
jmp_tgt  in  ADDR_W  jump target address
stall  in  1  hold PC (memory or hazard stall)
pc  out  ADDR_W  current fetch address to instruction memory
fetch_valid  out  1  instruction fetched at pc is architecturally valid
flush  out  1  squash front-end pipeline registers this cycle
redirect_cnt  out  16  taken-redirect counter (present only with macro)

Behaviour:
- Reset: rst_n=0 sampled at a clock edge sets pc=RESET_PC, fetch_valid=0, flush=0, state=IDLE, counters=0. Reset overrides all other inputs, including mid-FLUSH.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - Entered only from reset; lasts exactly 1 cycle after rst_n rises.
  - Transitions to RUN with fetch_valid=1 and pc=RESET_PC.
- RUN:
  - Redirect is taken when sel_valid=1, stall=0 and NextInstrSel is 01 or 10.
    - 01: pc <= branch_tgt.
    - 10: pc <= jmp_tgt.
    - Next state FLUSH; flush=1 and fetch_valid=0 from the following cycle.
  - Otherwise, when stall=0: pc <= pc + PC_INC, with modulo 2^ADDR_W wrap-around. Sequential advance happens even when sel_valid=0.
  - NextInstrSel=11 is treated as 00 (sequential); no error output.
- FLUSH:
  - A down-counter is loaded with FLUSH_CYC on entry.
  - flush=1 and fetch_valid=0 while the counter is nonzero. The counter decrements each cycle and ignores stall.
  - pc continues advancing by PC_INC from the target each non-stalled cycle, so the target instruction is fetched in the first FLUSH cycle.
  - When the counter reaches 1, the next state is RUN and fetch_valid=1.
  - Redirects with sel_valid=1 during FLUSH are ignored (wrong-path).
- stall=1 in RUN: pc, state and fetch_valid hold; redirects are not taken until stall drops. The decoder holds sel_valid.
- Simultaneous stall=1 and sel_valid=1: the stall wins.
- Latency: a redirect presented at edge N gives the new pc visible after edge N, and fetch_valid returns after edge N+FLUSH_CYC.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro PC_REDIRECT_STATS_EN.
- Defined: redirect_cnt port exists. It increments on every taken redirect, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pc_ctrl_pkg:
  - NextInstrSel encoding localparams: SEL_SEQ=2'b00, SEL_BR=2'b01, SEL_JMP=2'b10, SEL_RSV=2'b11.
  - FSM state enum {IDLE, RUN, FLUSH}.
- Natural sub-module: pc_flush_counter, a loadable down-counter with zero flag.

Test Plan:
- Reset release, stall=0, sel_valid=0 -> pc 0,0,4,8,12 on successive cycles; fetch_valid 0 then 1 from the RUN cycle.
- At pc=8: sel_valid=1, NextInstrSel=01, branch_tgt=0x100 -> pc=0x100 next cycle, flush=1 for 2 cycles, then fetch_valid=1 with pc=0x108.
- NextInstrSel=10, jmp_tgt=0x40, while stall=1 for 3 cycles -> pc holds for 3 cycles, then jumps to 0x40 on the first unstalled edge.
- Second branch during FLUSH to 0x200 -> ignored; pc continues from the first target.
- NextInstrSel=11, sel_valid=1 -> behaves as sequential: pc+4, no flush.
- rst_n=0 in the middle of FLUSH -> pc=RESET_PC, flush=0, fetch_valid=0 the next cycle.
- pc=0xFFFFFFFC, sequential advance -> pc wraps to 0. With PC_REDIRECT_STATS_EN: 3 redirects -> redirect_cnt=3.
